// File: rtl/com_to_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : com_to_fifo_pkg
//  Brief    : Shared types, error bit indices and CRC8 helper for the
//             board-link receive path.
//  Revision : 1.0  initial release
// ============================================================================
package com_to_fifo_pkg;

  localparam logic [7:0] DEFAULT_CRC_POLY = 8'h07;

  // Bit positions inside the sticky error vector
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAME   = 1;
  localparam int ERR_CRC     = 2;
  localparam int ERR_OVERRUN = 3;

  typedef enum logic [2:0] {
    BYTE_IDLE      = 3'd0,
    BYTE_START     = 3'd1,
    BYTE_DATA      = 3'd2,
    BYTE_PARITY    = 3'd3,
    BYTE_STOP      = 3'd4,
    BYTE_WAIT_HIGH = 3'd5
  } byteState_t;

  typedef enum logic [0:0] {
    PKT_EXP_DATA = 1'b0,
    PKT_EXP_CRC  = 1'b1
  } pktState_t;

  // CRC8 of a single byte: init 0, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8(input logic [7:0] data, input logic [7:0] poly);
    logic [7:0] crc;
    crc = data;
    for (int i = 0; i < 8; i++) begin
      crc = crc[7] ? ((crc << 1) ^ poly) : (crc << 1);
    end
    return crc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/com_to_fifo_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Brief    : UART byte receiver: rx synchronizer, bit timing, byte FSM and
//             even-parity / stop-bit checking.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte
  import com_to_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);

  logic          r_rxMeta;
  logic          r_rxs;
  byteState_t    r_state;
  byteState_t    w_nextState;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_parityBad;
  logic          w_sample;

  assign byte_data = r_shift;

  // Two-flop synchronizer; the line idles high so reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxMeta <= 1'b1;
      r_rxs    <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxs    <= r_rxMeta;
    end
  end

  // Mid-bit strobe: half a bit after the falling edge, then every full bit
  always_comb begin
    w_sample = (r_state == BYTE_START) ? (r_cnt == HALF_BIT) : (r_cnt == FULL_BIT);
  end

  // Byte FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= BYTE_IDLE;
    else        r_state <= w_nextState;
  end

  // Byte FSM next state and per-frame result strobes
  always_comb begin
    w_nextState = r_state;
    byte_valid  = 1'b0;
    parity_err  = 1'b0;
    frame_err   = 1'b0;
    case (r_state)
      BYTE_IDLE: begin
        if (!r_rxs && enable) w_nextState = BYTE_START;
      end
      BYTE_START: begin
        if (w_sample) w_nextState = r_rxs ? BYTE_IDLE : BYTE_DATA;
      end
      BYTE_DATA: begin
        if (w_sample && (r_bitIdx == 3'd7)) w_nextState = BYTE_PARITY;
      end
      BYTE_PARITY: begin
        if (w_sample) w_nextState = BYTE_STOP;
      end
      BYTE_STOP: begin
        if (w_sample) begin
          byte_valid  = r_rxs && !r_parityBad;
          parity_err  = r_parityBad;
          frame_err   = !r_rxs;
          w_nextState = r_rxs ? BYTE_IDLE : BYTE_WAIT_HIGH;
        end
      end
      BYTE_WAIT_HIGH: begin
        if (r_rxs) w_nextState = BYTE_IDLE;
      end
      default: w_nextState = BYTE_IDLE;
    endcase
  end

  // Bit timer, data shift register and parity accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_shift     <= '0;
      r_parityBad <= 1'b0;
    end else begin
      // Counter reads 1 in the first cycle after the start edge is seen
      if ((r_state == BYTE_IDLE) || w_sample) r_cnt <= CW'(1);
      else                                    r_cnt <= r_cnt + 1'b1;
      if (w_sample) begin
        case (r_state)
          BYTE_START:  r_bitIdx <= '0;
          BYTE_DATA: begin
            r_shift  <= {r_rxs, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
          end
          BYTE_PARITY: r_parityBad <= ^{r_shift, r_rxs};
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/com_to_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : com_to_fifo
//  Brief    : Receives data/CRC8 byte pairs over UART, verifies them and
//             writes good data bytes into the receive FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module com_to_fifo
  import com_to_fifo_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] CRC_POLY     = DEFAULT_CRC_POLY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  input  logic       fifo_busy,
  input  logic       fifo_full,
  output logic       fifo_we,
  output logic [7:0] fifo_data,
  output logic [7:0] last_data,
  output logic [7:0] last_crc,
  output logic [3:0] error,
  output logic       isFinish
);

  logic       w_byteValid;
  logic [7:0] w_byte;
  logic       w_parityErr;
  logic       w_frameErr;
  pktState_t  r_pkt;
  pktState_t  w_nextPkt;
  logic [7:0] r_crcCalc;
  logic [7:0] r_lastData;
  logic [7:0] r_lastCrc;
  logic [7:0] r_fifoData;
  logic [3:0] r_error;
  logic       r_isFinish;
  logic       r_pending;
  logic       w_issue;
  logic       w_crcMatch;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rxByte (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .enable    (enable),
    .byte_valid(w_byteValid),
    .byte_data (w_byte),
    .parity_err(w_parityErr),
    .frame_err (w_frameErr)
  );

  assign last_data = r_lastData;
  assign last_crc  = r_lastCrc;
  assign fifo_data = r_fifoData;
  assign error     = r_error;
  assign isFinish  = r_isFinish;

  // The pending write leaves in the first non-busy cycle; a full FIFO eats it
  assign w_issue    = r_pending && !fifo_busy;
  assign fifo_we    = w_issue && !fifo_full;
  assign w_crcMatch = (w_byte == r_crcCalc);

  // Packet FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pkt <= PKT_EXP_DATA;
    else        r_pkt <= w_nextPkt;
  end

  // Packet FSM next state: any bad frame resynchronizes to a data byte
  always_comb begin
    w_nextPkt = r_pkt;
    if (w_parityErr || w_frameErr) begin
      w_nextPkt = PKT_EXP_DATA;
    end else if (w_byteValid) begin
      w_nextPkt = (r_pkt == PKT_EXP_DATA) ? PKT_EXP_CRC : PKT_EXP_DATA;
    end
  end

  // Pair datapath, CRC compare, sticky errors and FIFO write bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crcCalc  <= '0;
      r_lastData <= '0;
      r_lastCrc  <= '0;
      r_fifoData <= '0;
      r_error    <= '0;
      r_isFinish <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_isFinish <= 1'b0;
      if (w_issue) begin
        r_pending <= 1'b0;
        if (fifo_full) r_error[ERR_OVERRUN] <= 1'b1;
      end
      if (w_parityErr) r_error[ERR_PARITY] <= 1'b1;
      if (w_frameErr)  r_error[ERR_FRAME]  <= 1'b1;
      if (w_byteValid) begin
        if (r_pkt == PKT_EXP_DATA) begin
          r_lastData <= w_byte;
          r_crcCalc  <= crc8(w_byte, CRC_POLY);
        end else begin
          r_lastCrc  <= w_byte;
          r_isFinish <= 1'b1;
          if (!w_crcMatch) begin
            r_error[ERR_CRC] <= 1'b1;
          end else if (r_pending) begin
            // Previous byte still waiting for the FIFO: the new one is lost
            r_error[ERR_OVERRUN] <= 1'b1;
          end else begin
            r_pending  <= 1'b1;
            r_fifoData <= r_lastData;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_com_to_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_com_to_fifo
//  Brief    : Self-checking bench for com_to_fifo with a pair-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_com_to_fifo;

  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       rx        = 1'b1;
  logic       enable    = 1'b1;
  logic       fifo_busy = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_we;
  logic [7:0] fifo_data;
  logic [7:0] last_data;
  logic [7:0] last_crc;
  logic [3:0] error;
  logic       isFinish;

  com_to_fifo #(
    .CLKS_PER_BIT(N),
    .CRC_POLY    (8'h07)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .enable   (enable),
    .fifo_busy(fifo_busy),
    .fifo_full(fifo_full),
    .fifo_we  (fifo_we),
    .fifo_data(fifo_data),
    .last_data(last_data),
    .last_crc (last_crc),
    .error    (error),
    .isFinish (isFinish)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Edge index, used to schedule model outcomes
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned at;
    bit          finish;
    bit          setData;
    logic [7:0]  data;
    bit          setCrc;
    logic [7:0]  crc;
    logic [3:0]  errSet;
    bit          push;
    logic [7:0]  pushData;
  } outcome_t;

  outcome_t   evq[$];
  outcome_t   curO;
  bit         mHaveData = 1'b0;
  logic [7:0] mData     = 8'h00;
  logic [7:0] eLastData = 8'h00;
  logic [7:0] eLastCrc  = 8'h00;
  logic [7:0] ePendData = 8'h00;
  logic [3:0] eErr      = 4'h0;
  bit         ePending  = 1'b0;
  bit         eFinish;
  bit         eWe;
  int         nWrites   = 0;
  logic [7:0] lastWrite = 8'h00;

  // CRC as the remainder of d(x)*x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] refCrc8(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  // Decide what a frame does to the pair protocol; effects land at 'when'
  task automatic modelFrame(input logic [7:0] d, input bit badPar, input bit stopVal,
                            input int unsigned when);
    outcome_t o;
    o = '{at: when, finish: 1'b0, setData: 1'b0, data: 8'h00, setCrc: 1'b0,
          crc: 8'h00, errSet: 4'h0, push: 1'b0, pushData: 8'h00};
    if (badPar || !stopVal) begin
      o.errSet[0] = badPar;
      o.errSet[1] = !stopVal;
      mHaveData   = 1'b0;
    end else if (!mHaveData) begin
      o.setData = 1'b1;
      o.data    = d;
      mHaveData = 1'b1;
      mData     = d;
    end else begin
      o.setCrc  = 1'b1;
      o.crc     = d;
      o.finish  = 1'b1;
      mHaveData = 1'b0;
      if (d == refCrc8(mData)) begin
        o.push     = 1'b1;
        o.pushData = mData;
      end else begin
        o.errSet[2] = 1'b1;
      end
    end
    evq.push_back(o);
  endtask

  task automatic clearModel();
    evq.delete();
    mHaveData = 1'b0;
    mData     = 8'h00;
    eLastData = 8'h00;
    eLastCrc  = 8'h00;
    ePendData = 8'h00;
    eErr      = 4'h0;
    ePending  = 1'b0;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    eFinish = 1'b0;
    while (evq.size() > 0 && evq[0].at <= cyc) begin
      curO = evq.pop_front();
      if (curO.finish)  eFinish   = 1'b1;
      if (curO.setData) eLastData = curO.data;
      if (curO.setCrc)  eLastCrc  = curO.crc;
      eErr = eErr | curO.errSet;
      if (curO.push) begin
        if (ePending) eErr[3] = 1'b1;
        else begin
          ePending  = 1'b1;
          ePendData = curO.pushData;
        end
      end
    end
    eWe = ePending && !fifo_busy && !fifo_full;
    chk("fifo_we",   32'(fifo_we),   32'(eWe));
    chk("isFinish",  32'(isFinish),  32'(eFinish));
    chk("last_data", 32'(last_data), 32'(eLastData));
    chk("last_crc",  32'(last_crc),  32'(eLastCrc));
    chk("error",     32'(error),     32'(eErr));
    if (ePending) chk("fifo_data_held", 32'(fifo_data), 32'(ePendData));
    if (fifo_we) begin
      nWrites++;
      lastWrite = fifo_data;
    end
    if (ePending && !fifo_busy) begin
      ePending = 1'b0;
      if (fifo_full) eErr[3] = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One UART frame; a stop bit of 0 is followed by 3 more bit times of low line
  task automatic sendFrame(input logic [7:0] d, input bit badPar, input bit stopVal);
    logic [10:0] bits;
    bits = {stopVal, (^d) ^ badPar, d, 1'b0};
    @(posedge clk);
    #1;
    if (enable) modelFrame(d, badPar, stopVal, cyc + 3 + H + 10 * N);
    for (int j = 0; j < 11; j++) begin
      rx = bits[j];
      repeat (N) @(posedge clk);
      #1;
    end
    if (!stopVal) begin
      repeat (3 * N) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // Holds fifo_busy for 20 cycles centred on the completion of the next frame
  task automatic busyWindow(input int unsigned tgt);
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
    fifo_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    fifo_busy = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_fifo_we"},   32'(fifo_we),   32'h0);
    chk({tag, "_fifo_data"}, 32'(fifo_data), 32'h0);
    chk({tag, "_last_data"}, 32'(last_data), 32'h0);
    chk({tag, "_last_crc"},  32'(last_crc),  32'h0);
    chk({tag, "_error"},     32'(error),     32'h0);
    chk({tag, "_isFinish"},  32'(isFinish),  32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned tgt;
    int          nBefore;

    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(posedge clk);
    #3 reset = 1'b1;
    idle(20);

    // Good pair
    sendFrame(8'hA5, 1'b0, 1'b1);
    sendFrame(8'h72, 1'b0, 1'b1);
    idle(5);
    chk("pair_last_data", 32'(last_data), 32'hA5);
    chk("pair_last_crc",  32'(last_crc),  32'h72);
    chk("pair_error",     32'(error),     32'h0);
    chk("pair_writes",    32'(nWrites),   32'd1);
    chk("pair_fifo_byte", 32'(lastWrite), 32'hA5);

    // CRC mismatch, then a matching pair
    sendFrame(8'h01, 1'b0, 1'b1);
    sendFrame(8'h06, 1'b0, 1'b1);
    idle(5);
    chk("crcbad_error",  32'(error),   32'h4);
    chk("crcbad_writes", 32'(nWrites), 32'd1);
    sendFrame(8'h01, 1'b0, 1'b1);
    sendFrame(8'h07, 1'b0, 1'b1);
    idle(5);
    chk("crcgood_writes", 32'(nWrites),   32'd2);
    chk("crcgood_byte",   32'(lastWrite), 32'h01);

    // Parity fault on what would be the CRC byte resyncs to a data byte
    sendFrame(8'h55, 1'b0, 1'b1);
    sendFrame(8'hA5, 1'b1, 1'b1);
    idle(5);
    chk("parity_error", 32'(error), 32'h5);
    sendFrame(8'h10, 1'b0, 1'b1);
    sendFrame(8'h70, 1'b0, 1'b1);
    idle(5);
    chk("parity_resync_byte", 32'(lastWrite), 32'h10);

    // Framing fault with the line held low afterwards
    sendFrame(8'h33, 1'b0, 1'b0);
    idle(N);
    chk("frame_error", 32'(error), 32'h7);
    sendFrame(8'h01, 1'b0, 1'b1);
    sendFrame(8'h07, 1'b0, 1'b1);
    idle(5);
    chk("frame_resync_writes", 32'(nWrites), 32'd4);

    // Short low glitch
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    idle(2 * N);
    chk("glitch_error", 32'(error), 32'h7);

    // Frames while disabled are ignored
    enable = 1'b0;
    sendFrame(8'h5A, 1'b0, 1'b1);
    sendFrame(refCrc8(8'h5A), 1'b0, 1'b1);
    idle(4);
    enable = 1'b1;
    idle(4);
    chk("disabled_writes", 32'(nWrites), 32'd4);
    sendFrame(8'h22, 1'b0, 1'b1);
    sendFrame(refCrc8(8'h22), 1'b0, 1'b1);
    idle(5);

    // FIFO busy across the CRC byte completion
    nBefore = nWrites;
    sendFrame(8'h81, 1'b0, 1'b1);
    tgt = cyc + 4 + H + 10 * N - 10;
    fork
      sendFrame(refCrc8(8'h81), 1'b0, 1'b1);
      busyWindow(tgt);
    join
    idle(5);
    chk("busy_one_write", 32'(nWrites - nBefore), 32'd1);
    chk("busy_byte",      32'(lastWrite),         32'h81);

    // Same with the FIFO full: dropped, overrun flagged
    nBefore   = nWrites;
    fifo_full = 1'b1;
    sendFrame(8'h42, 1'b0, 1'b1);
    tgt = cyc + 4 + H + 10 * N - 10;
    fork
      sendFrame(refCrc8(8'h42), 1'b0, 1'b1);
      busyWindow(tgt);
    join
    idle(5);
    fifo_full = 1'b0;
    chk("full_no_write", 32'(nWrites - nBefore), 32'd0);
    chk("full_error",    32'(error),             32'hF);

    // Asynchronous reset in the middle of a frame's data bits
    sendFrame(8'h3C, 1'b0, 1'b1);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4 * N) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    clearModel();
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    idle(10);
    nBefore = nWrites;
    sendFrame(8'hA5, 1'b0, 1'b1);
    sendFrame(8'h72, 1'b0, 1'b1);
    idle(5);
    chk("post_reset_last_data", 32'(last_data),           32'hA5);
    chk("post_reset_last_crc",  32'(last_crc),            32'h72);
    chk("post_reset_error",     32'(error),               32'h0);
    chk("post_reset_writes",    32'(nWrites - nBefore),   32'd1);
    chk("post_reset_byte",      32'(lastWrite),           32'hA5);

    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/com_to_fifo.md
# com_to_fifo

Serial receive path for the board link, and the far end of the transmit chain that sends each data byte followed by its CRC8 byte as UART frames. The block deserializes UART frames from `rx` and checks parity, stop bit and the CRC8 of each data/CRC byte pair. Each verified data byte is written into the receive FIFO through the FIFO's write handshake. The most recent data/CRC pair and sticky error flags are exported for the seven-segment display.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit; even, at least 4.
- `CRC_POLY`, default 8'h07: CRC8 polynomial; init 8'h00, MSB-first, no reflection, no final XOR.

Ports:
- `clk`  in  1  block clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, asynchronous; idles high.
- `enable`  in  1  allows a new frame to start.
- `fifo_busy`  in  1  FIFO cannot accept a write this cycle.
- `fifo_full`  in  1  FIFO has no free entry.
- `fifo_we`  out  1  one-cycle write strobe.
- `fifo_data`  out  8  byte being written; valid while `fifo_we`=1.
- `last_data`  out  8  last data byte received, before its CRC is checked.
- `last_crc`  out  8  last CRC byte received.
- `error`  out  4  sticky flags: [0] parity, [1] framing, [2] CRC mismatch, [3] overrun.
- `isFinish`  out  1  one-cycle pulse per completed pair, pass or fail.

## Operation
- `rx` passes through a two-flop synchronizer; all decisions use the synchronized value `rxs`.
- Frame format: start(0), 8 data bits LSB first, even parity bit, stop(1).
- Byte FSM states and transitions:
  - IDLE: on `rxs`=0 with `enable`=1, go to START. `enable` is sampled only in IDLE.
  - START: at the mid-bit sample, if `rxs`=1 it is a glitch; return to IDLE with no error.
  - DATA: sample 8 bits, LSB first.
  - PARITY: sample the parity bit.
  - STOP: sample the stop bit.
  - WAIT_HIGH: entered only after a stop bit of 0; return to IDLE once `rxs`=1.
- Packet FSM states and transitions:
  - EXP_DATA: a good byte is loaded into `last_data`, the CRC8 of it is computed, go to EXP_CRC.
  - EXP_CRC: a good byte is loaded into `last_crc`, compared with the computed CRC, `isFinish` pulses, return to EXP_DATA.
  - CRC match: the write becomes pending. Mismatch: set `error[2]`, nothing written.
- A parity error or a stop bit of 0 sets `error[0]` or `error[1]` respectively. The byte is discarded and the packet FSM resets to EXP_DATA.
- Pending write:
  - Issue `fifo_we` in the first cycle with `fifo_busy`=0.
  - `fifo_data` is held stable until the write is issued.
  - If `fifo_full`=1 in that cycle, drop the byte and set `error[3]`.
  - A new pass while a write is still pending: the new byte is dropped and `error[3]` set.
- `error` bits clear only on reset.
- Reset mid-frame aborts the frame: both FSMs go to IDLE/EXP_DATA and all outputs return to 0.

## Timing
- Reset values: `fifo_we`=0, `fifo_data`=0, `last_data`=0, `last_crc`=0, `error`=0, `isFinish`=0.
- Let t be the first cycle with `rxs`=0 while in IDLE.
- Sample points:
  - start at t+CLKS_PER_BIT/2
  - data bit i at t+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT
  - parity at +9·CLKS_PER_BIT
  - stop at +10·CLKS_PER_BIT
- One cycle after the stop sample of a CRC byte: `last_crc` is updated, `isFinish`=1, and `fifo_we` rises at the earliest if `fifo_busy`=0.
- After the stop sample of a good frame, the FSM returns to IDLE in the next cycle, so back-to-back frames are accepted.

## Structure
- Shared package holds:
  - state encodings for the byte and packet FSMs
  - error bit indices (ERR_PARITY=0, ERR_FRAME=1, ERR_CRC=2, ERR_OVERRUN=3)
  - the default `CRC_POLY`
- Sub-module `uart_rx_byte` contains the synchronizer, bit counter, byte FSM and parity check. It outputs `byte_valid`, `byte`, `parity_err` and `frame_err`.
- The top level contains the packet FSM, CRC8 datapath and FIFO write handshake.

## Test plan
- Good pair: send 0xA5 (parity 0), then 0x72 (parity 0) → `last_data`=A5, `last_crc`=72, one `fifo_we` with `fifo_data`=A5, `error`=0.
- CRC mismatch: send 0x01, then 0x06 → `isFinish` pulses, no `fifo_we`, `error`=4'b0100. A following 0x01, 0x07 pair writes 0x01.
- Parity and framing faults:
  - 0xA5 with parity bit 1 → `error[0]` set, packet FSM stays in EXP_DATA.
  - Stop bit held 0 → `error[1]` set; no new start is accepted until `rx` returns high.
- FIFO handshake: `fifo_busy`=1 for 20 cycles across a good pair → `fifo_we` is issued exactly once, in the first cycle after busy falls, with data stable. Repeat with `fifo_full`=1 → no write, `error[3]` set.
- Glitch, enable and reset:
  - `rx` low for 3 cycles → no frame, no error.
  - `enable`=0 → frames ignored.
  - `reset` asserted mid-DATA → all outputs 0 asynchronously; the next full pair is received correctly.
